// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the hazard control unit.
//   CNT_W       : width of the saturating performance counters
//   hz_state_e  : FSM state encoding (RUN = 0, STALL = 1)
//   reg_idx_t   : architectural register index
//   rd_match()  : destination/source match, x0 never matches
package hazard_ctrl_unit_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        StRun   = 1'b0,
        StStall = 1'b1
    } hz_state_e;

    typedef logic [4:0] reg_idx_t;

    function automatic logic rd_match(reg_idx_t rd, reg_idx_t rs1, reg_idx_t rs2,
                                      logic uses_rs2);
        return (rd != 5'd0) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears the count
//   inc   : increment on this edge (held at all-ones once reached)
//   clear : synchronous clear, has priority over inc
//   count : current count value
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: detects load-use and branch-in-ID data hazards, stalls
// the front end for the required number of cycles and flushes IF/ID on a taken
// branch.
//   clk, rst                 : clock, asynchronous active-high reset
//   id_rs1, id_rs2           : ID source registers; id_uses_rs2 qualifies rs2
//   id_branch                : ID holds a branch resolved in ID
//   ex_rd, mem_rd            : EX / MEM destination registers
//   ex_MemRead, ex_Reg_Write : EX control bits; mem_MemRead : MEM control bit
//   beq_pc_Sel               : branch taken in ID
//   ctrl_sgnl_sel            : 1 passes decoded controls, 0 inserts a bubble
//   pc_write, If_Id_write    : front-end write enables
//   If_id_flush              : IF/ID flush on taken branch
//   stall_cycles, flush_count: saturating performance counters
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             id_branch,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       mem_rd,
    input  logic             ex_MemRead,
    input  logic             ex_Reg_Write,
    input  logic             mem_MemRead,
    input  logic             beq_pc_Sel,
    output logic             ctrl_sgnl_sel,
    output logic             pc_write,
    output logic             If_Id_write,
    output logic             If_id_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    hz_state_e  state_q, state_d;
    logic [1:0] stall_left_q, stall_left_d;
    logic       ex_match, mem_match;
    logic [1:0] need_n;
    logic       stall_now;

    assign ex_match  = rd_match(ex_rd,  id_rs1, id_rs2, id_uses_rs2);
    assign mem_match = rd_match(mem_rd, id_rs1, id_rs2, id_uses_rs2);

    // Ordered so later (larger) needs override smaller ones: result is the maximum.
    always_comb begin
        need_n = 2'd0;
        if (ex_MemRead && ex_match) begin
            need_n = 2'd1;
        end
        if (id_branch && ex_Reg_Write && !ex_MemRead && ex_match) begin
            need_n = 2'd1;
        end
        if (id_branch && mem_MemRead && mem_match) begin
            need_n = 2'd1;
        end
        if (id_branch && ex_MemRead && ex_match) begin
            need_n = 2'd2;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            stall_left_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            stall_left_q <= stall_left_d;
        end
    end

    // Next state
    always_comb begin
        state_d      = state_q;
        stall_left_d = stall_left_q;
        unique case (state_q)
            StRun: begin
                if (need_n != 2'd0) begin
                    stall_left_d = need_n - 2'd1;
                    if (need_n > 2'd1) begin
                        state_d = StStall;
                    end
                end
            end
            StStall: begin
                // Inputs are ignored here; hazards are re-evaluated once back in RUN.
                stall_left_d = stall_left_q - 2'd1;
                if (stall_left_q <= 2'd1) begin
                    stall_left_d = 2'd0;
                    state_d      = StRun;
                end
            end
            default: begin
                state_d      = StRun;
                stall_left_d = 2'd0;
            end
        endcase
    end

    // Outputs (Mealy in RUN); everything deasserted while in reset
    always_comb begin
        stall_now     = (state_q == StStall) || (need_n != 2'd0);
        ctrl_sgnl_sel = !rst && !stall_now;
        pc_write      = !rst && !stall_now;
        If_Id_write   = !rst && !stall_now;
        // Branch operands are stale during a stall, so the stall wins.
        If_id_flush   = !rst && beq_pc_Sel && !stall_now;
    end

    sat_counter #(
        .Width(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (!ctrl_sgnl_sel),
        .clear(1'b0),
        .count(stall_cycles)
    );

    sat_counter #(
        .Width(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (If_id_flush),
        .clear(1'b0),
        .count(flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit.
module tb_hazard_ctrl_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
    logic        id_uses_rs2, id_branch, ex_MemRead, ex_Reg_Write, mem_MemRead, beq_pc_Sel;
    logic        ctrl_sgnl_sel, pc_write, If_Id_write, If_id_flush;
    logic [15:0] stall_cycles, flush_count;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    hazard_ctrl_unit dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs2  (id_uses_rs2),
        .id_branch    (id_branch),
        .ex_rd        (ex_rd),
        .mem_rd       (mem_rd),
        .ex_MemRead   (ex_MemRead),
        .ex_Reg_Write (ex_Reg_Write),
        .mem_MemRead  (mem_MemRead),
        .beq_pc_Sel   (beq_pc_Sel),
        .ctrl_sgnl_sel(ctrl_sgnl_sel),
        .pc_write     (pc_write),
        .If_Id_write  (If_Id_write),
        .If_id_flush  (If_id_flush),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
        id_uses_rs2 = 1'b0; id_branch = 1'b0; ex_MemRead = 1'b0;
        ex_Reg_Write = 1'b0; mem_MemRead = 1'b0; beq_pc_Sel = 1'b0;
    endtask

    // Inputs change on the falling edge; outputs sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic check_front(input string tag, input logic exp_run);
        check_eq({tag, "_ctrl"}, 32'(ctrl_sgnl_sel), 32'(exp_run));
        check_eq({tag, "_pc"},   32'(pc_write),      32'(exp_run));
        check_eq({tag, "_ifid"}, 32'(If_Id_write),   32'(exp_run));
    endtask

    task automatic branch_load();
        idle_inputs();
        id_branch = 1'b1; ex_MemRead = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        beq_pc_Sel = 1'b1;
        next_cycle(); #1;
        check_front("rst", 1'b0);
        check_eq("rst_flush", 32'(If_id_flush), 0);
        check_eq("rst_scnt", 32'(stall_cycles), 0);
        check_eq("rst_fcnt", 32'(flush_count), 0);

        next_cycle(); rst = 1'b0; idle_inputs(); #1;
        check_front("idle", 1'b1);
        check_eq("idle_flush", 32'(If_id_flush), 0);

        // Load-use: one bubble
        next_cycle(); ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; #1;
        check_front("lu", 1'b0);
        next_cycle(); idle_inputs(); #1;
        check_front("lu_after", 1'b1);
        check_eq("lu_scnt", 32'(stall_cycles), 1);

        // x0 never matches
        next_cycle(); ex_MemRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; #1;
        check_front("x0", 1'b1);

        // rs2 only counts when used
        next_cycle(); idle_inputs(); ex_MemRead = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; #1;
        check_front("rs2_unused", 1'b1);
        next_cycle(); id_uses_rs2 = 1'b1; #1;
        check_front("rs2_used", 1'b0);
        next_cycle(); idle_inputs(); #1;
        check_eq("rs2_scnt", 32'(stall_cycles), 2);

        // Branch after load: two stall cycles, taken branch suppressed while stalling
        next_cycle(); branch_load(); #1;
        check_front("bl_1", 1'b0);
        next_cycle(); idle_inputs(); beq_pc_Sel = 1'b1; #1;
        check_front("bl_2", 1'b0);
        check_eq("bl_flush_sup", 32'(If_id_flush), 0);
        next_cycle(); idle_inputs(); #1;
        check_front("bl_done", 1'b1);
        check_eq("bl_scnt", 32'(stall_cycles), 4);
        check_eq("bl_fcnt", 32'(flush_count), 0);

        // Branch on ALU result in EX: one stall; plain ALU dependency: none
        next_cycle(); id_branch = 1'b1; ex_Reg_Write = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; #1;
        check_front("br_alu", 1'b0);
        next_cycle(); id_branch = 1'b0; #1;
        check_front("alu_nobr", 1'b1);

        // Branch on load in MEM: one stall; non-branch: none
        next_cycle(); idle_inputs(); id_branch = 1'b1; mem_MemRead = 1'b1; mem_rd = 5'd4;
        id_rs1 = 5'd4; #1;
        check_front("br_mem", 1'b0);
        next_cycle(); id_branch = 1'b0; #1;
        check_front("mem_nobr", 1'b1);
        check_eq("mem_scnt", 32'(stall_cycles), 6);

        // Taken branch with no hazard
        next_cycle(); idle_inputs(); beq_pc_Sel = 1'b1; #1;
        check_eq("tk_flush", 32'(If_id_flush), 1);
        check_front("tk", 1'b1);
        next_cycle(); idle_inputs(); #1;
        check_eq("tk_flush_off", 32'(If_id_flush), 0);
        check_eq("tk_fcnt", 32'(flush_count), 1);

        // Residual hazard after leaving STALL restarts the stall
        next_cycle(); branch_load(); #1;
        check_front("res_1", 1'b0);
        next_cycle(); #1;
        check_front("res_2", 1'b0);
        next_cycle(); #1;
        check_front("res_3", 1'b0);
        next_cycle(); idle_inputs(); #1;
        check_front("res_4", 1'b0);
        next_cycle(); #1;
        check_front("res_done", 1'b1);
        check_eq("res_scnt", 32'(stall_cycles), 10);

        // Reset at the second stall cycle aborts the stall
        next_cycle(); branch_load(); #1;
        check_front("rs_1", 1'b0);
        next_cycle(); rst = 1'b1; idle_inputs(); beq_pc_Sel = 1'b1; #1;
        check_front("rs_in", 1'b0);
        check_eq("rs_flush", 32'(If_id_flush), 0);
        check_eq("rs_scnt", 32'(stall_cycles), 0);
        check_eq("rs_fcnt", 32'(flush_count), 0);
        next_cycle(); rst = 1'b0; idle_inputs(); #1;
        check_front("rs_after", 1'b1);

        // Saturation of stall_cycles under a permanent load-use hazard
        next_cycle(); ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
        for (int i = 0; i < 65540; i++) begin
            next_cycle();
        end
        #1;
        check_front("sat", 1'b0);
        check_eq("sat_scnt", 32'(stall_cycles), 32'h0000_FFFF);
        next_cycle(); #1;
        check_eq("sat_hold", 32'(stall_cycles), 32'h0000_FFFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
